// File: rtl/fifo_unpacker_if.sv
// rtl/fifo_unpacker_if.sv - upstream FIFO read port and downstream halfword stream bundle
//
// Signals:
//   fifo_usedw   upstream FIFO occupancy, 0 = empty
//   fifo_read    one-cycle read request to the upstream FIFO
//   fifo_rdata   64-bit read data, valid while fifo_rvalid = 1
//   fifo_rvalid  read-data strobe, two cycles after the accepted read
//   out_data     current halfword
//   out_valid    out_data holds a halfword
//   out_ready    downstream accepts the halfword this cycle
// Modports: master = unpacker side, slave = FIFO/sink side.
interface fifo_unpacker_if;
    logic [7:0]  fifo_usedw;
    logic        fifo_read;
    logic [63:0] fifo_rdata;
    logic        fifo_rvalid;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (
        input  fifo_usedw,
        output fifo_read,
        input  fifo_rdata,
        input  fifo_rvalid,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        output fifo_usedw,
        input  fifo_read,
        output fifo_rdata,
        output fifo_rvalid,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/fifo_unpacker.sv
// rtl/fifo_unpacker.sv - reads 64-bit words from a FIFO and emits them as four 16-bit halfwords
//
// Parameters:
//   LSB_FIRST   1 = bits [15:0] emitted first, 0 = bits [63:48] emitted first
//   RD_TIMEOUT  cycles allowed in WAIT before the read is declared lost
// Ports:
//   clk       single clock, rising edge
//   reset     asynchronous active-high reset
//   bus       FIFO read port and halfword stream (fifo_unpacker_if.master)
//   busy      high whenever the FSM is not idle
//   err       sticky read-timeout flag
//   err_clr   synchronous clear of err (a simultaneous timeout wins)
//   hw_count  halfwords transferred, wraps at 16 bits
module fifo_unpacker #(
    parameter bit LSB_FIRST  = 1'b1,
    parameter int RD_TIMEOUT = 4
) (
    input  logic               clk,
    input  logic               reset,
    fifo_unpacker_if.master    bus,
    output logic               busy,
    output logic               err,
    input  logic               err_clr,
    output logic [15:0]        hw_count
);

    // The wait counter only ever needs to hold 0 .. RD_TIMEOUT-1.
    localparam int CW = (RD_TIMEOUT < 3) ? 1 : $clog2(RD_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(RD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        SHIFT = 2'd3
    } state_t;

    state_t         state;
    logic [63:0]    hold;
    logic [1:0]     idx;
    logic [CW-1:0]  cnt;

    function automatic logic [15:0] pick(input logic [63:0] w, input logic [1:0] i);
        logic [1:0] s;
        s = LSB_FIRST ? i : (2'd3 - i);
        case (s)
            2'd0:    pick = w[15:0];
            2'd1:    pick = w[31:16];
            2'd2:    pick = w[47:32];
            default: pick = w[63:48];
        endcase
    endfunction

    // Outputs are registered: every transition loads the output values that
    // belong to the state being entered, so they line up with the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            bus.fifo_read <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= 16'h0000;
            busy          <= 1'b0;
            err           <= 1'b0;
            hw_count      <= 16'h0000;
            hold          <= 64'h0;
            idx           <= 2'd0;
            cnt           <= '0;
        end else begin
            bus.fifo_read <= 1'b0;
            // Clear first so a timeout assignment below overrides it.
            if (err_clr) begin
                err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (bus.fifo_usedw != 8'd0) begin
                        state         <= REQ;
                        bus.fifo_read <= 1'b1;
                        busy          <= 1'b1;
                    end
                end
                REQ: begin
                    state <= WAIT;
                    cnt   <= '0;
                end
                WAIT: begin
                    if (bus.fifo_rvalid) begin
                        hold          <= bus.fifo_rdata;
                        idx           <= 2'd0;
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= pick(bus.fifo_rdata, 2'd0);
                        state         <= SHIFT;
                    end else if (cnt == CNT_LAST) begin
                        err   <= 1'b1;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (bus.out_ready) begin
                        hw_count <= hw_count + 16'd1;
                        idx      <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            bus.out_valid <= 1'b0;
                            if (bus.fifo_usedw != 8'd0) begin
                                state         <= REQ;
                                bus.fifo_read <= 1'b1;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            bus.out_data <= pick(hold, idx + 2'd1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_unpacker.sv
// tb/tb_fifo_unpacker.sv - self-checking bench for fifo_unpacker (both halfword orders)
module tb_fifo_unpacker;

    localparam int RD_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        err_clr = 1'b0;
    logic        ready = 1'b0;
    logic [63:0] rdata = 64'h0;
    logic        auto_en = 1'b1;
    logic        force_rvalid = 1'b0;
    logic [7:0]  pushed = 8'd0;
    logic [7:0]  reads_done = 8'd0;
    logic [1:0]  rd_pipe = 2'b00;
    logic [7:0]  usedw;
    logic        rvalid;

    logic        busy1, busy2, err1, err2;
    logic [15:0] hwc1, hwc2;

    int tests = 0;
    int fails = 0;
    int hw_exp = 0;

    fifo_unpacker_if b1 ();
    fifo_unpacker_if b2 ();

    assign usedw  = pushed - reads_done;
    assign rvalid = rd_pipe[1] | force_rvalid;

    assign b1.fifo_usedw  = usedw;
    assign b1.fifo_rdata  = rdata;
    assign b1.fifo_rvalid = rvalid;
    assign b1.out_ready   = ready;
    assign b2.fifo_usedw  = usedw;
    assign b2.fifo_rdata  = rdata;
    assign b2.fifo_rvalid = rvalid;
    assign b2.out_ready   = ready;

    fifo_unpacker #(.LSB_FIRST(1'b1), .RD_TIMEOUT(RD_TIMEOUT)) dut_lsb (
        .clk(clk), .reset(reset), .bus(b1),
        .busy(busy1), .err(err1), .err_clr(err_clr), .hw_count(hwc1)
    );

    fifo_unpacker #(.LSB_FIRST(1'b0), .RD_TIMEOUT(RD_TIMEOUT)) dut_msb (
        .clk(clk), .reset(reset), .bus(b2),
        .busy(busy2), .err(err2), .err_clr(err_clr), .hw_count(hwc2)
    );

    always #5 clk = ~clk;

    // Upstream FIFO model: each accepted read returns rdata two cycles later.
    always @(posedge clk) begin
        rd_pipe <= {rd_pipe[0], b1.fifo_read & auto_en};
        if (b1.fifo_read) reads_done <= reads_done + 8'd1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " lsb out_valid"}, 64'(b1.out_valid), 64'd0);
        check({tag, " msb out_valid"}, 64'(b2.out_valid), 64'd0);
        check({tag, " lsb busy"},      64'(busy1), 64'd0);
        check({tag, " msb busy"},      64'(busy2), 64'd0);
        check({tag, " lsb fifo_read"}, 64'(b1.fifo_read), 64'd0);
    endtask

    typedef struct {
        logic [63:0] word;
        logic [63:0] lsb_seq;  // emission order, first halfword in [63:48]
        logic [63:0] msb_seq;
    } vec_t;

    // Pushes nwords copies of w, runs the stream and compares both orders.
    task automatic run_words(input logic [63:0] w, input logic [63:0] lsb_seq,
                             input logic [63:0] msb_seq, input int nwords, input bit toggle);
        logic [15:0] got1[$];
        logic [15:0] got2[$];
        int          acc_cyc[$];
        int          rd_cyc[$];
        logic        pv;
        logic        pacc;
        logic [15:0] pd;
        int          n;
        got1.delete(); got2.delete(); acc_cyc.delete(); rd_cyc.delete();
        pv = 1'b0; pacc = 1'b0; pd = 16'h0;
        rdata = w;
        pushed = pushed + 8'(nwords);
        n = 4 * nwords;
        for (int cyc = 0; cyc < 40 * nwords; cyc++) begin
            @(negedge clk);
            ready = toggle ? cyc[0] : 1'b1;
            if (b1.fifo_read) rd_cyc.push_back(cyc);
            if (toggle && pv && !pacc && b1.out_valid)
                check("hold stable lsb", 64'(b1.out_data), 64'(pd));
            if (b1.out_valid && ready) begin
                got1.push_back(b1.out_data);
                acc_cyc.push_back(cyc);
            end
            if (b2.out_valid && ready) got2.push_back(b2.out_data);
            pv = b1.out_valid; pacc = ready; pd = b1.out_data;
            if (got1.size() >= n && got2.size() >= n) break;
        end
        @(negedge clk);
        ready = 1'b0;
        @(negedge clk);
        check("lsb halfword count", 64'(got1.size()), 64'(n));
        check("msb halfword count", 64'(got2.size()), 64'(n));
        for (int i = 0; i < n && i < got1.size() && i < got2.size(); i++) begin
            check($sformatf("lsb hw%0d", i), 64'(got1[i]), 64'(lsb_seq[63 - 16 * (i % 4) -: 16]));
            check($sformatf("msb hw%0d", i), 64'(got2[i]), 64'(msb_seq[63 - 16 * (i % 4) -: 16]));
        end
        check("read pulses", 64'(rd_cyc.size()), 64'(nwords));
        if (!toggle) begin
            for (int i = 1; i < rd_cyc.size(); i++)
                check("read spacing", 64'(rd_cyc[i] - rd_cyc[i - 1]), 64'd7);
            if (acc_cyc.size() == n)
                check("accept span", 64'(acc_cyc[n - 1] - acc_cyc[0]), 64'(7 * (nwords - 1) + 3));
        end
        hw_exp = hw_exp + n;
        check("lsb hw_count", 64'(hwc1), 64'(hw_exp));
        check("msb hw_count", 64'(hwc2), 64'(hw_exp));
        check_idle_outputs("after run");
    endtask

    initial begin
        vec_t vecs[3];
        int   n;
        int   acc;
        bit   seen;

        vecs[0] = '{64'h0123_4567_89AB_CDEF, 64'hCDEF_89AB_4567_0123, 64'h0123_4567_89AB_CDEF};
        vecs[1] = '{64'hFFFF_0000_AAAA_5555, 64'h5555_AAAA_0000_FFFF, 64'hFFFF_0000_AAAA_5555};
        vecs[2] = '{64'h8000_0001_0002_7FFF, 64'h7FFF_0002_0001_8000, 64'h8000_0001_0002_7FFF};

        // Reset state
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        check("reset out_data", 64'(b1.out_data), 64'd0);
        check("reset err", 64'(err1), 64'd0);
        check("reset hw_count", 64'(hwc1), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single words, ready held high, both halfword orders
        for (int v = 0; v < 3; v++)
            run_words(vecs[v].word, vecs[v].lsb_seq, vecs[v].msb_seq, 1, 1'b0);

        // Backpressure: ready alternates every cycle
        run_words(vecs[0].word, vecs[0].lsb_seq, vecs[0].msb_seq, 1, 1'b1);

        // Three words queued: back-to-back words, reads 7 cycles apart
        run_words(vecs[1].word, vecs[1].lsb_seq, vecs[1].msb_seq, 3, 1'b0);

        // Lost read: no rvalid ever returns
        auto_en = 1'b0;
        pushed = pushed + 8'd1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = b1.fifo_read;
        end
        check("timeout read issued", 64'(seen), 64'd1);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n++;
            if (err1) break;
        end
        check("timeout latency", 64'(n), 64'(RD_TIMEOUT + 1));
        check("timeout err msb", 64'(err2), 64'd1);
        check_idle_outputs("timeout");
        repeat (2) @(negedge clk);
        check("err sticky", 64'(err1), 64'd1);
        check("timeout stays idle", 64'(busy1), 64'd0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err cleared lsb", 64'(err1), 64'd0);
        check("err cleared msb", 64'(err2), 64'd0);
        auto_en = 1'b1;
        check("no count on timeout", 64'(hwc1), 64'(hw_exp));

        // Reset after the second halfword, then a stray rvalid
        rdata = vecs[0].word;
        pushed = pushed + 8'd1;
        acc = 0;
        for (int i = 0; i < 30 && acc < 2; i++) begin
            @(negedge clk);
            ready = 1'b1;
            if (b1.out_valid) acc++;
        end
        check("pre-reset accepts", 64'(acc), 64'd2);
        @(posedge clk);
        #2;
        check("pre-reset valid", 64'(b1.out_valid), 64'd1);
        check("pre-reset data", 64'(b1.out_data), 64'h4567);
        reset = 1'b1;
        #1;
        check("async out_valid", 64'(b1.out_valid), 64'd0);
        check("async out_data", 64'(b1.out_data), 64'd0);
        check("async hw_count", 64'(hwc1), 64'd0);
        check("async busy", 64'(busy2), 64'd0);
        hw_exp = 0;
        @(negedge clk);
        reset = 1'b0;
        ready = 1'b0;
        force_rvalid = 1'b1;
        @(negedge clk);
        force_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_idle_outputs("stray rvalid");
        end
        check("stray err", 64'(err1), 64'd0);
        check("stray hw_count", 64'(hwc1), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
